mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port main memory between two requesters: instruction fetch (F port, read-only) and data access (D port, used by LW/SW/push/pop).
- Sits between the multicycle control unit/datapath and the memory.
- Sequences each access through a fixed-latency wait-state FSM and returns a one-cycle Done pulse, so the control unit can stall until its access completes.

Parameters:
- ADDR_W, 16, address width of both ports and memory
- DATA_W, 16, data width
- WAIT_CYCLES, 1, extra memory cycles per access (0..15)

Ports:
- CLK  in  1  system clock; all logic on the rising edge
- RST  in  1  synchronous, active-high reset
- FReq  in  1  fetch request; level, held until FDone
- FAddr  in  ADDR_W  fetch address
- FRdata  out  DATA_W  fetch read data; valid while FDone is high
- FDone  out  1  one-cycle completion pulse to the fetch requester
- DReq  in  1  data request; level, held until DDone
- DWe  in  1  1 = write, 0 = read
- DAddr  in  ADDR_W  data address
- DWdata  in  DATA_W  write data
- DRdata  out  DATA_W  data read data; valid while DDone is high
- DDone  out  1  one-cycle completion pulse to the data requester
- MemEn  out  1  memory enable
- MemWe  out  1  memory write strobe
- MemAddr  out  ADDR_W  memory address
- MemWdata  out  DATA_W  memory write data
- MemRdata  in  DATA_W  memory read data
- Busy  out  1  high in ACCESS and RESP
- Owner  out  2  00 none, 01 fetch, 10 data

Behaviour:
- Reset: state IDLE, wait counter 0, latched address/we/wdata 0, all outputs 0, LastOwner=fetch.
- State IDLE:
  - If DReq or FReq is high, pick a winner (see arbitration) and latch its address, we (fetch forces 0) and wdata.
  - Load counter with WAIT_CYCLES, set Owner, go to ACCESS.
  - Otherwise stay in IDLE; MemEn=0.
- State ACCESS:
  - MemEn=1; MemAddr and MemWdata come from the latches.
  - MemWe=latched we, asserted only in the first ACCESS cycle.
  - If counter=0: capture MemRdata into the read register and go to RESP.
  - Otherwise decrement the counter.
- State RESP:
  - The owner's Done is high for exactly one cycle; the matching Rdata output shows the captured word.
  - For writes, Rdata is undefined.
  - Update LastOwner, clear Owner, go to IDLE.
- Latency: a request seen in IDLE at cycle t gets Done at cycle t+WAIT_CYCLES+2.
- Rdata outputs hold their value until the next RESP for the same port.
- Arbitration: data has fixed priority over fetch when both request in the same IDLE cycle.
- The loser keeps its request asserted and is served next; no request is dropped.
- A request still high in the cycle after Done is treated as a new request.
- Request inputs are sampled only in IDLE; changes during ACCESS/RESP are ignored.
- FDone and DDone are never high in the same cycle.
- Reset mid-access: immediate return to IDLE with no Done pulse and MemWe low from the next cycle; requesters must re-request.
- Counter width is 4 bits.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration. On a simultaneous request, the port that is not LastOwner wins; LastOwner resets to fetch, so data wins the first tie.
- Undefined: fixed data-over-fetch priority; the LastOwner register may be optimised out.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encodings IDLE=2'd0, ACCESS=2'd1, RESP=2'd2
  - owner codes OWN_NONE/OWN_F/OWN_D
  - the default WAIT_CYCLES constant
- One natural sub-module, mem_arb_pick: combinational winner select from FReq, DReq and LastOwner; the ARB_RR_EN switch lives here.

Test Plan:
- Fetch read, WAIT_CYCLES=1, FReq at cycle 0, FAddr=0x0010, memory word 0x7A3C -> MemEn high cycles 1-2, FDone high only at cycle 3, FRdata=0x7A3C.
- Data write, WAIT_CYCLES=0, DWe=1, DAddr=0x0100, DWdata=0xBEEF -> MemWe high exactly one cycle with MemAddr=0x0100 and MemWdata=0xBEEF; DDone at cycle 2; a read of 0x0100 returns 0xBEEF.
- FReq and DReq both asserted at cycle 0 (fixed priority) -> D served first (DDone at cycle 3), then F (FDone at cycle 7); Owner sequence 10 then 01.
- With ARB_RR_EN, both requests held continuously for 4 accesses -> grants alternate D, F, D, F.
- RST asserted in the second ACCESS cycle of a write -> no Done pulse, MemWe=0 and Busy=0 on the next cycle, Owner=00.
- DReq held high through DDone -> a second access starts immediately and a second DDone arrives WAIT_CYCLES+2 cycles after re-entering IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the main-memory port arbiter.
// State and owner encodings plus the default wait-state count.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int WAIT_CYCLES_DEF = 1;
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requests.
// ARB_RR_EN: round-robin on ties; otherwise data has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   freq_i,
  input  logic   dreq_i,
  input  owner_e last_i,
  output owner_e grant_o
);

  owner_e tie;

`ifdef ARB_RR_EN
  assign tie = (last_i == OWN_D) ? OWN_F : OWN_D;
`else
  logic unused_last;
  assign unused_last = ^last_i;
  assign tie = OWN_D;
`endif

  always_comb begin
    grant_o = OWN_NONE;
    if (dreq_i && freq_i) begin
      grant_o = tie;
    end else if (dreq_i) begin
      grant_o = OWN_D;
    end else if (freq_i) begin
      grant_o = OWN_F;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters.
// Fixed-latency wait-state FSM with a one-cycle Done pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FReq,
  input  logic [ADDR_W-1:0] FAddr,
  output logic [DATA_W-1:0] FRdata,
  output logic              FDone,
  input  logic              DReq,
  input  logic              DWe,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWdata,
  output logic [DATA_W-1:0] DRdata,
  output logic              DDone,
  output logic              MemEn,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic [DATA_W-1:0] MemRdata,
  output logic              Busy,
  output logic [1:0]        Owner
);

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  owner_e            grant;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] frd_q, frd_d;
  logic [DATA_W-1:0] drd_q, drd_d;

  mem_arb_pick u_pick (
    .freq_i  (FReq),
    .dreq_i  (DReq),
    .last_i  (last_q),
    .grant_o (grant)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      last_q  <= OWN_F;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      frd_q   <= '0;
      drd_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      frd_q   <= frd_d;
      drd_q   <= drd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    frd_d   = frd_q;
    drd_d   = drd_q;
    unique case (state_q)
      IDLE: begin
        if (grant != OWN_NONE) begin
          owner_d = grant;
          cnt_d   = WAIT_LD;
          state_d = ACCESS;
          if (grant == OWN_D) begin
            addr_d  = DAddr;
            we_d    = DWe;
            wdata_d = DWdata;
          end else begin
            addr_d  = FAddr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (owner_q == OWN_D) begin
            drd_d = MemRdata;
          end else begin
            frd_d = MemRdata;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        last_d  = owner_q;
        owner_d = OWN_NONE;
        state_d = IDLE;
      end
      default: begin
        owner_d = OWN_NONE;
        state_d = IDLE;
      end
    endcase
  end

  // Counter equals the load value only in the first ACCESS cycle.
  assign MemEn    = (state_q == ACCESS);
  assign MemWe    = MemEn && we_q && (cnt_q == WAIT_LD);
  assign MemAddr  = addr_q;
  assign MemWdata = wdata_q;
  assign Busy     = (state_q == ACCESS) || (state_q == RESP);
  assign Owner    = owner_q;
  assign FDone    = (state_q == RESP) && (owner_q == OWN_F);
  assign DDone    = (state_q == RESP) && (owner_q == OWN_D);
  assign FRdata   = frd_q;
  assign DRdata   = drd_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter.
// Transaction-level model predicts grant order, Done timing and data.
module tb_mem_port_arbiter;

  localparam int W = 1;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        FReq = 1'b0;
  logic [15:0] FAddr = '0;
  logic [15:0] FRdata;
  logic        FDone;
  logic        DReq = 1'b0;
  logic        DWe = 1'b0;
  logic [15:0] DAddr = '0;
  logic [15:0] DWdata = '0;
  logic [15:0] DRdata;
  logic        DDone;
  logic        MemEn;
  logic        MemWe;
  logic [15:0] MemAddr;
  logic [15:0] MemWdata;
  logic [15:0] MemRdata;
  logic        Busy;
  logic [1:0]  Owner;

  mem_port_arbiter #(
    .ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W)
  ) dut (
    .CLK(CLK), .RST(RST),
    .FReq(FReq), .FAddr(FAddr), .FRdata(FRdata), .FDone(FDone),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata),
    .DRdata(DRdata), .DDone(DDone),
    .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemWdata(MemWdata), .MemRdata(MemRdata),
    .Busy(Busy), .Owner(Owner)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] init_word(input int i);
    return 16'(i * 40503) ^ 16'hA5C3;
  endfunction

  logic [15:0] mem [256];
  assign MemRdata = mem[MemAddr[7:0]];

  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (MemEn && MemWe) begin
      mem[MemAddr[7:0]] <= MemWdata;
    end
  end

  typedef struct {
    int          port;
    int          g;
    int          d;
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t        q[$];
  logic [15:0] ref_mem [256];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          free_t = 0;
  int          last_p = 0;
  bit          mon_en = 1'b0;
  bit          issuing = 1'b0;
  bit          act [2];
  bit          gnt [2];
  int          done_t [2];
  logic [15:0] a [2];
  logic [15:0] wd [2];
  bit          we [2];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  // Requesters and model; ports: 0 = fetch, 1 = data.
  task automatic model_cycle();
    int   w;
    exp_t e;
    for (int p = 0; p < 2; p++) begin
      if (act[p] && gnt[p] && cyc > done_t[p]) act[p] = 1'b0;
      if (issuing && !act[p] && $urandom_range(0, 99) < 45) begin
        act[p] = 1'b1;
        gnt[p] = 1'b0;
        a[p]   = 16'($urandom_range(0, 31));
        we[p]  = (p == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        wd[p]  = 16'($urandom);
      end
    end
    FReq   = act[0];
    FAddr  = (act[0] && !gnt[0]) ? a[0] : 16'($urandom);
    DReq   = act[1];
    DAddr  = (act[1] && !gnt[1]) ? a[1] : 16'($urandom);
    DWe    = (act[1] && !gnt[1]) ? we[1] : 1'($urandom);
    DWdata = (act[1] && !gnt[1]) ? wd[1] : 16'($urandom);
    if (cyc >= free_t) begin
      w = -1;
      if (act[0] && !gnt[0] && act[1] && !gnt[1]) begin
`ifdef ARB_RR_EN
        w = (last_p == 1) ? 0 : 1;
`else
        w = 1;
`endif
      end else if (act[1] && !gnt[1]) begin
        w = 1;
      end else if (act[0] && !gnt[0]) begin
        w = 0;
      end
      if (w >= 0) begin
        gnt[w]    = 1'b1;
        done_t[w] = cyc + W + 2;
        free_t    = cyc + W + 3;
        last_p    = w;
        e.port    = w;
        e.g       = cyc;
        e.d       = cyc + W + 2;
        e.addr    = a[w];
        e.we      = we[w];
        e.wdata   = wd[w];
        if (we[w]) begin
          ref_mem[a[w][7:0]] = wd[w];
          e.rdata = '0;
        end else begin
          e.rdata = ref_mem[a[w][7:0]];
        end
        q.push_back(e);
      end
    end
  endtask

  always @(negedge CLK) begin : monitor
    logic [1:0] eo;
    bit eb, em, ewe, edf, edd;
    if (mon_en) begin
      eo = 2'd0; eb = 0; em = 0; ewe = 0; edf = 0; edd = 0;
      if (q.size() > 0 && cyc > q[0].g && cyc <= q[0].d) begin
        eo  = 2'(q[0].port + 1);
        eb  = 1;
        em  = (cyc < q[0].d);
        ewe = em && q[0].we && (cyc == q[0].g + 1);
        edf = (cyc == q[0].d) && (q[0].port == 0);
        edd = (cyc == q[0].d) && (q[0].port == 1);
      end
      chk("Owner", 32'(Owner), 32'(eo));
      chk("Busy", 32'(Busy), 32'(eb));
      chk("MemEn", 32'(MemEn), 32'(em));
      chk("MemWe", 32'(MemWe), 32'(ewe));
      chk("FDone", 32'(FDone), 32'(edf));
      chk("DDone", 32'(DDone), 32'(edd));
      if (ewe) begin
        chk("MemAddr", 32'(MemAddr), 32'(q[0].addr));
        chk("MemWdata", 32'(MemWdata), 32'(q[0].wdata));
      end
      if (edf) chk("FRdata", 32'(FRdata), 32'(q[0].rdata));
      if (edd && !q[0].we) chk("DRdata", 32'(DRdata), 32'(q[0].rdata));
      if (q.size() > 0 && cyc >= q[0].d) void'(q.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_Busy", 32'(Busy), 32'd0);
    chk("rst_Owner", 32'(Owner), 32'd0);
    chk("rst_MemEn", 32'(MemEn), 32'd0);
    chk("rst_MemWe", 32'(MemWe), 32'd0);
    chk("rst_FDone", 32'(FDone), 32'd0);
    chk("rst_DDone", 32'(DDone), 32'd0);
    chk("rst_FRdata", 32'(FRdata), 32'd0);
    chk("rst_DRdata", 32'(DRdata), 32'd0);
    RST    = 1'b0;
    mon_en = 1'b1;
    for (int c = 0; c < 700; c++) begin
      if (c > 0) begin
        @(posedge CLK);
        #1;
      end
      cyc     = c;
      issuing = (c < 640);
      model_cycle();
    end
    mon_en = 1'b0;
    chk("queue_drained", 32'(q.size()), 32'd0);

    // Write cut short by reset in its second ACCESS cycle.
    @(posedge CLK); #1; cyc++;
    FReq = 1'b0; DReq = 1'b1; DWe = 1'b1;
    DAddr = 16'h0005; DWdata = 16'hBEEF;
    @(posedge CLK); #1; cyc++;
    chk("rw_MemWe1", 32'(MemWe), 32'd1);
    chk("rw_MemAddr", 32'(MemAddr), 32'h0005);
    chk("rw_MemWdata", 32'(MemWdata), 32'hBEEF);
    chk("rw_Owner1", 32'(Owner), 32'd2);
    @(posedge CLK); #1; cyc++;
    chk("rw_MemWe2", 32'(MemWe), 32'd0);
    chk("rw_Busy2", 32'(Busy), 32'd1);
    RST = 1'b1; DReq = 1'b0;
    @(posedge CLK); #1; cyc++;
    chk("rr_MemWe", 32'(MemWe), 32'd0);
    chk("rr_Busy", 32'(Busy), 32'd0);
    chk("rr_Owner", 32'(Owner), 32'd0);
    chk("rr_DDone", 32'(DDone), 32'd0);
    chk("rr_MemEn", 32'(MemEn), 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1; cyc++;
    chk("rr_DDone2", 32'(DDone), 32'd0);
    chk("rr_Busy2", 32'(Busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
